sram_share_arbiter: RTL and testbench

//  Shares one single-port sprite/image SRAM (1-cycle registered read, write-first,
//  en/we/addr/data_i/data_o interface) between two masters: M0 = VGA pixel fetcher
//  (read-only, latency-critical), M1 = animation/update engine (read or write).

---
 rtl/sram_share_arbiter_if.sv | 38 +++
 rtl/sram_share_arbiter.sv | 61 ++++++
 tb/tb_sram_share_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_share_arbiter_if.sv
// Signal bundle between the two SRAM masters, the arbiter and the shared SRAM.
// slave = arbiter view; master = requesters plus SRAM side, driven by the environment.
interface sram_share_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  m0_req;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_WIDTH-1:0] m1_rdata;

    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, sram_rdata,
        output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, sram_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_share_arbiter.sv
// Shares one single-port SRAM between a read-only pixel fetcher (M0, priority)
// and an update engine (M1, read/write) with a starvation guard for M1.
module sram_share_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sram_share_arbiter_if.slave      bus
);
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;
    logic       force_m1;
    logic       pend_m0;
    logic       pend_m1;

    always_comb begin
        bus.m1_gnt     = bus.m1_req & (force_m1 | ~bus.m0_req);
        bus.m0_gnt     = bus.m0_req & ~(force_m1 & bus.m1_req);
        bus.sram_en    = bus.m0_gnt | bus.m1_gnt;
        bus.sram_we    = bus.m1_gnt & bus.m1_we;
        bus.sram_addr  = bus.m1_gnt ? bus.m1_addr : bus.m0_addr;
        bus.sram_wdata = bus.m1_wdata;
    end

    // Read tag captured on the grant edge; SRAM data arrives the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_m0 <= 1'b0;
            pend_m1 <= 1'b0;
        end else begin
            pend_m0 <= bus.m0_gnt;
            pend_m1 <= bus.m1_gnt & ~bus.m1_we;
        end
    end

    always_comb begin
        bus.m0_rvalid = pend_m0;
        bus.m1_rvalid = pend_m1;
        bus.m0_rdata  = pend_m0 ? bus.sram_rdata : '0;
        bus.m1_rdata  = pend_m1 ? bus.sram_rdata : '0;
    end

    // Force is raised the cycle after the counter sits at MAX_WAIT while still denied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            force_m1 <= 1'b0;
        end else if (!bus.m1_req || bus.m1_gnt) begin
            wait_cnt <= '0;
            force_m1 <= 1'b0;
        end else begin
            if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (wait_cnt >= MAX_WAIT_C) begin
                force_m1 <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_share_arbiter.sv
// Directed bench for sram_share_arbiter with a behavioural write-first SRAM.
module tb_sram_share_arbiter;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem [0:65535];

    sram_share_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    sram_share_arbiter #(.MAX_WAIT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle registered read, write-first; backdoor preload port
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.sram_en) begin
            if (bus.sram_we) begin
                mem[bus.sram_addr] <= bus.sram_wdata;
                bus.sram_rdata     <= bus.sram_wdata;
            end else begin
                bus.sram_rdata <= mem[bus.sram_addr];
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic idle_reqs();
        bus.m0_req   = 1'b0;
        bus.m1_req   = 1'b0;
        bus.m1_we    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.m0_req  = 1'b1;
        bus.m0_addr = 16'h0002;
        bus.m1_req  = 1'b1;
        bus.m1_addr = 16'h0003;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rvalid: got m0=%b m1=%b want 0 0", bus.m0_rvalid, bus.m1_rvalid);
            end
            n_checks++;
            if (bus.m0_rdata !== 8'h00 || bus.m1_rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_rdata: got m0=%h m1=%h want 00 00", bus.m0_rdata, bus.m1_rdata);
            end
        end
        idle_reqs();
        #1;
        n_checks++;
        if (bus.m0_gnt !== 1'b0 || bus.m1_gnt !== 1'b0 || bus.sram_en !== 1'b0 || bus.sram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: got gnt=%b%b en=%b we=%b want 00 0 0",
                     bus.m0_gnt, bus.m1_gnt, bus.sram_en, bus.sram_we);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_rvalid: got m0=%b m1=%b want 0 0", bus.m0_rvalid, bus.m1_rvalid);
            end
        end
    endtask

    task automatic test_m0_stream();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 8'(8'h10 + i - 1) || bus.m1_rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL m0_stream_data[%0d]: got v=%b d=%h m1v=%b want 1 %h 0",
                             i - 1, bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid, 8'(8'h10 + i - 1));
                end
            end
            if (i < 4) begin
                bus.m0_req  = 1'b1;
                bus.m0_addr = 16'(i);
                #1;
                n_checks++;
                if (bus.m0_gnt !== 1'b1 || bus.sram_en !== 1'b1 || bus.sram_we !== 1'b0 || bus.sram_addr !== 16'(i)) begin
                    n_fail++;
                    $display("FAIL m0_stream_gnt[%0d]: got gnt=%b en=%b we=%b addr=%h want 1 1 0 %h",
                             i, bus.m0_gnt, bus.sram_en, bus.sram_we, bus.sram_addr, 16'(i));
                end
            end else begin
                bus.m0_req = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL m0_stream_tail: got v=%b d=%h want 0 00", bus.m0_rvalid, bus.m0_rdata);
        end
    endtask

    task automatic test_contention();
        logic exp_m1g;
        logic exp_m1v;
        logic exp_m0v;
        @(negedge clk);
        bus.m0_req  = 1'b1;
        bus.m0_addr = 16'h0020;
        bus.m1_req  = 1'b1;
        bus.m1_we   = 1'b0;
        bus.m1_addr = 16'h0030;
        for (int c = 0; c < 34; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_m1g = ((c % 17) == 16);
            exp_m1v = (c > 0) && ((c % 17) == 0);
            exp_m0v = (c > 0) && ((c % 17) != 0);
            n_checks++;
            if (bus.m1_gnt !== exp_m1g || bus.m0_gnt !== !exp_m1g) begin
                n_fail++;
                $display("FAIL contention_gnt[%0d]: got m0=%b m1=%b want m0=%b m1=%b",
                         c, bus.m0_gnt, bus.m1_gnt, !exp_m1g, exp_m1g);
            end
            n_checks++;
            if (bus.m1_rvalid !== exp_m1v || bus.m0_rvalid !== exp_m0v ||
                bus.m0_rdata !== (exp_m0v ? 8'h5C : 8'h00) || bus.m1_rdata !== (exp_m1v ? 8'h3E : 8'h00)) begin
                n_fail++;
                $display("FAIL contention_rdata[%0d]: got v=%b%b d0=%h d1=%h want v=%b%b",
                         c, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata, exp_m0v, exp_m1v);
            end
        end
        idle_reqs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_force_release();
        @(negedge clk);
        bus.m0_req  = 1'b1;
        bus.m0_addr = 16'h0020;
        bus.m1_req  = 1'b1;
        bus.m1_we   = 1'b0;
        bus.m1_addr = 16'h0030;
        repeat (16) @(negedge clk);
        bus.m1_req = 1'b0;
        #1;
        n_checks++;
        if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL force_no_req: got m0=%b m1=%b want 1 0", bus.m0_gnt, bus.m1_gnt);
        end
        @(negedge clk);
        bus.m1_req = 1'b1;
        #1;
        n_checks++;
        if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0 || dut.wait_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL force_cleared: got m0=%b m1=%b cnt=%0d want 1 0 0", bus.m0_gnt, bus.m1_gnt, dut.wait_cnt);
        end
        idle_reqs();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        bus.m1_req   = 1'b1;
        bus.m1_we    = 1'b1;
        bus.m1_addr  = 16'h0100;
        bus.m1_wdata = 8'hA5;
        #1;
        n_checks++;
        if (bus.m1_gnt !== 1'b1 || bus.sram_we !== 1'b1 || bus.sram_addr !== 16'h0100 || bus.sram_wdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_issue: got gnt=%b we=%b addr=%h wd=%h want 1 1 0100 a5",
                     bus.m1_gnt, bus.sram_we, bus.sram_addr, bus.sram_wdata);
        end
        @(negedge clk);
        bus.m1_req  = 1'b0;
        bus.m1_we   = 1'b0;
        bus.m0_req  = 1'b1;
        bus.m0_addr = 16'h0100;
        #1;
        n_checks++;
        if (bus.m1_rvalid !== 1'b0 || bus.m0_rvalid !== 1'b0 || bus.m0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_no_rvalid: got m1v=%b m0v=%b m0g=%b want 0 0 1", bus.m1_rvalid, bus.m0_rvalid, bus.m0_gnt);
        end
        @(negedge clk);
        bus.m0_req = 1'b0;
        n_checks++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 8'hA5 || bus.m1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_readback: got v=%b d=%h m1v=%b want 1 a5 0", bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid);
        end
    endtask

    task automatic test_no_crossing();
        @(negedge clk);
        bus.m1_req  = 1'b1;
        bus.m1_we   = 1'b0;
        bus.m1_addr = 16'h0040;
        #1;
        n_checks++;
        if (bus.m1_gnt !== 1'b1 || bus.sram_addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL nx_m1_gnt: got gnt=%b addr=%h want 1 0040", bus.m1_gnt, bus.sram_addr);
        end
        @(negedge clk);
        bus.m1_req  = 1'b0;
        bus.m0_req  = 1'b1;
        bus.m0_addr = 16'h0041;
        n_checks++;
        if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 8'h77 || bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL nx_m1_data: got m1v=%b d1=%h m0v=%b d0=%h want 1 77 0 00",
                     bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid, bus.m0_rdata);
        end
        @(negedge clk);
        bus.m0_req = 1'b0;
        n_checks++;
        if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 8'h88 || bus.m1_rvalid !== 1'b0 || bus.m1_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL nx_m0_data: got m0v=%b d0=%h m1v=%b d1=%h want 1 88 0 00",
                     bus.m0_rvalid, bus.m0_rdata, bus.m1_rvalid, bus.m1_rdata);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.m0_req  = 1'b1;
        bus.m0_addr = 16'h0001;
        bus.m1_req  = 1'b1;
        bus.m1_we   = 1'b0;
        bus.m1_addr = 16'h0030;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut.wait_cnt !== 8'd3 || bus.m0_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset: got cnt=%0d m0v=%b want 3 1", dut.wait_cnt, bus.m0_rvalid);
        end
        reset_n = 1'b0;
        idle_reqs();
        #1;
        n_checks++;
        if (bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 8'h00 || dut.wait_cnt !== 8'd0 || dut.force_m1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_in_reset: got v=%b d=%h cnt=%0d f=%b want 0 00 0 0",
                     bus.m0_rvalid, bus.m0_rdata, dut.wait_cnt, dut.force_m1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0 || dut.wait_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL mid_after_release: got m0v=%b m1v=%b cnt=%0d want 0 0 0",
                         bus.m0_rvalid, bus.m1_rvalid, dut.wait_cnt);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        pl_en          = 1'b0;
        pl_addr        = '0;
        pl_data        = '0;
        bus.m0_addr    = '0;
        bus.m1_addr    = '0;
        bus.m1_wdata   = '0;
        bus.sram_rdata = '0;
        idle_reqs();
        for (int i = 0; i < 4; i++) preload(16'(i), 8'(8'h10 + i));
        preload(16'h0020, 8'h5C);
        preload(16'h0030, 8'h3E);
        preload(16'h0040, 8'h77);
        preload(16'h0041, 8'h88);
        test_reset();
        test_m0_stream();
        test_contention();
        test_force_release();
        test_write_then_read();
        test_no_crossing();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
